// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants for the BRAM port arbiter: port identifiers and default BRAM geometry.
package bram_port_arbiter_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/bram_port_arbiter.sv
// Round-robin (optional B priority) arbiter sharing one single-port BRAM; grant is same-cycle, ack/rdata one cycle later.
// Backpressure: the losing port sees gnt=0 and must hold its request until granted.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,

  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  input  logic                  b_prio,

  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,

  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  logic last_grant;
  logic ack_a;
  logic ack_b;
  logic rd_flag;
  logic win_b;
  logic conflict;

  assign conflict = a_req && b_req;

  // On a tie B wins under priority, or when A was the last port served.
  assign win_b = b_req && (!a_req || b_prio || (last_grant == PORT_A));

  // Grants are gated by reset so nothing reaches the BRAM while held in reset.
  always_comb begin
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    mem_we   = 1'b0;
    mem_addr = a_addr;
    mem_din  = a_wdata;
    if (rstn) begin
      if (win_b) begin
        b_gnt    = 1'b1;
        mem_we   = b_we;
        mem_addr = b_addr;
        mem_din  = b_wdata;
      end else if (a_req) begin
        a_gnt    = 1'b1;
        mem_we   = a_we;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant   <= PORT_B;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      rd_flag      <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      ack_a   <= a_gnt;
      ack_b   <= b_gnt;
      rd_flag <= (a_gnt || b_gnt) && !mem_we;
      if (a_gnt) begin
        last_grant <= PORT_A;
      end else if (b_gnt) begin
        last_grant <= PORT_B;
      end
      if (conflict && (conflict_cnt != {CNT_WIDTH{1'b1}})) begin
        conflict_cnt <= conflict_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign a_ack   = ack_a;
  assign b_ack   = ack_b;
  assign a_rdata = (ack_a && rd_flag) ? mem_dout : '0;
  assign b_rdata = (ack_b && rd_flag) ? mem_dout : '0;

endmodule
